uart_rx_deframer: RTL

- UART receive front end between the board-level `uart_rx` pin and the RISC-V SoC's consumers of received bytes (debug loader, UART peripheral).
- Synchronises the asynchronous line and detects the start bit.
- Samples 8N1 frames at mid-bit and presents each byte on a one-entry valid/ready holding register.
- Reports sticky framing and overrun errors.
- Runs in the divided 1 MHz system clock domain.

---
 rtl/uart_rx_deframer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop synchroniser, mid-bit sampling FSM, one-entry valid/ready byte holding register.
// Optional parity frame support is compiled in with `define UART_RX_PARITY_EN (8N1 otherwise).
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 104,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rxd,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       ovr_err_o,
  output logic       par_err_o,
  input  logic       err_clr_i,
  output logic       busy_o
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  state_t            state;
  logic              sync_p0;
  logic              sync_p1;
  logic              rxd_s;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shift;

  logic stop_tick;
  logic stop_good;
  logic frame_set;
  logic ovr_set;
  logic load;

  assign rxd_s = sync_p1;

  assign stop_tick = (state == S_STOP) && (cnt == CNT_FULL);
  assign stop_good = stop_tick && rxd_s;
  assign frame_set = stop_tick && !rxd_s;
  // A byte may replace the held one only if the holding register is empty or drained this cycle.
  assign load      = stop_good && (!rx_valid_o || rx_ready_i);
  assign ovr_set   = stop_good && rx_valid_o && !rx_ready_i;

`ifdef UART_RX_PARITY_EN
  logic par_set;

  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ((^d) ^ PARITY_ODD) == p;
  endfunction

  assign par_set = (state == S_PARITY) && (cnt == CNT_FULL) && !parity_ok(shift, rxd_s);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      sync_p0     <= 1'b1;
      sync_p1     <= 1'b1;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      ovr_err_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_o   <= 1'b0;
`endif
      busy_o      <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter on the raw line
      sync_p0 <= rxd;
      sync_p1 <= sync_p0;

      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state  <= S_START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxd_s) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shift <= {rxd_s, shift[DATA_W-1:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxd_s) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= S_WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HI: begin
          // A held-low line (break) must return high before a new start bit is accepted.
          if (rxd_s) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase

      if (load) begin
        rx_data_o  <= shift;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      frame_err_o <= (frame_err_o && !err_clr_i) || frame_set;
      ovr_err_o   <= (ovr_err_o && !err_clr_i) || ovr_set;
`ifdef UART_RX_PARITY_EN
      par_err_o   <= (par_err_o && !err_clr_i) || par_set;
`endif
    end
  end

endmodule
